// File: rtl/multi_debounce_pkg.sv
// rtl/multi_debounce_pkg.sv - shared debounce types and width helper
package multi_debounce_pkg;
`include "debounce_defs.vh"

  // Width able to hold 0..max_val-1, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: synchroniser, debounce FSM, edge and long-press pulses
module debounce_channel
  import multi_debounce_pkg::*;
#(
  parameter int COUNT_MAX = 600000,
  parameter int HOLD_MAX  = 60000000
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic btn_i,
  output logic btn_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_press_o
);
  localparam int CW = $clog2(COUNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_MAX - 1);

  logic          sync1_q, sync_q;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_q, btn_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= STABLE;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    btn_d   = btn_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE: begin
        if (sync_q != btn_q) state_d = CHANGING;
      end
      CHANGING: begin
        if (sync_q == btn_q) begin
          state_d = STABLE;
        end else if (cnt_q == CNT_LAST) begin
          // Edge pulses are registered alongside btn_q so they align with the new level.
          btn_d   = sync_q;
          rise_d  = sync_q;
          fall_d  = !sync_q;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = STABLE;
    endcase
  end

  assign btn_o  = btn_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

  if (HOLD_MAX == 0) begin : g_no_hold
    assign long_press_o = 1'b0;
  end else begin : g_hold
    localparam int HW = cnt_width(HOLD_MAX);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          fired_q, lp_q;

    always_comb begin
      hold_d = '0;
      if (btn_q) hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
    end

    // fired_q blocks repeat pulses until the button is released.
    always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
        hold_q  <= '0;
        fired_q <= 1'b0;
        lp_q    <= 1'b0;
      end else begin
        hold_q  <= hold_d;
        lp_q    <= btn_q && !fired_q && (hold_d == HOLD_LAST);
        fired_q <= btn_q && (fired_q || (hold_d == HOLD_LAST));
      end
    end

    assign long_press_o = lp_q;
  end
endmodule

// File: rtl/debounce_defs.vh
// rtl/debounce_defs.vh - debounce FSM state encodings
`ifndef DEBOUNCE_DEFS_VH
`define DEBOUNCE_DEFS_VH
typedef enum logic {
  STABLE   = 1'b0,
  CHANGING = 1'b1
} deb_state_e;
`endif

// File: rtl/multi_debounce.sv
// rtl/multi_debounce.sv - array of independent debounced button channels
module multi_debounce #(
  parameter int CHANNELS  = 4,
  parameter int COUNT_MAX = 600000,
  parameter int HOLD_MAX  = 60000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press
);
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .COUNT_MAX(COUNT_MAX),
      .HOLD_MAX (HOLD_MAX)
    ) u_ch (
      .clk_i       (clk),
      .resetn_i    (reset),
      .btn_i       (btn_in[g]),
      .btn_o       (btn_out[g]),
      .rise_o      (rise[g]),
      .fall_o      (fall[g]),
      .long_press_o(long_press[g])
    );
  end
endmodule
